phase_timer: RTL and testbench

PHASE_TIMER -- requirements
Module: PhaseTimer

---
 rtl/phase_timer.sv | 183 ++++++++++++++++++
 tb/tb_phase_timer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Countdown timer for one signal phase. A load starts (or restarts) a phase
//   of loadTime seconds; a prescaler divides clk down to one-second ticks and
//   timeLeft counts down on each tick. hold freezes the countdown, and
//   phaseDone pulses for one cycle when the phase expires.
//
//   Optional feature: define PHASE_TIMER_EXTEND_EN to let extend add
//   EXTEND_SEC seconds (saturating at 127) to a running or held phase.
//   Without the macro the extend port is present but has no effect.
//
// Parameters
//   CLK_PER_SEC : clock cycles per one-second tick (1..2^24)
//   EXTEND_SEC  : seconds added per extend pulse (1..127)
//
// Ports
//   clk       in   1  rising-edge clock
//   resetN    in   1  asynchronous active-low reset
//   loadTime  in   7  phase duration in seconds
//   load      in   1  start/restart the phase with loadTime
//   hold      in   1  freeze the countdown while high
//   extend    in   1  add EXTEND_SEC to the running phase (macro build only)
//   timeLeft  out  7  seconds remaining (register)
//   busy      out  1  high while the phase is running or held (register)
//   phaseDone out  1  one-cycle expiry pulse (register)
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int unsigned CLK_PER_SEC = 10,
  parameter int unsigned EXTEND_SEC  = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [6:0] loadTime,
  input  logic       load,
  input  logic       hold,
  input  logic       extend,
  output logic [6:0] timeLeft,
  output logic       busy,
  output logic       phaseDone
);

  // Prescaler wide enough to hold CLK_PER_SEC-1; at least one bit.
  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      time_q, time_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            wrap_s;
  logic            dec_s;
  logic [6:0]      base_s;
  logic            expire_s;

`ifdef PHASE_TIMER_EXTEND_EN
  // Add EXTEND_SEC seconds, clamping at the 7-bit maximum.
  function automatic logic [6:0] sat_add_f(input logic [6:0] a);
    logic [7:0] s;
    s = {1'b0, a} + 8'(EXTEND_SEC);
    if (s > 8'd127) begin
      return 7'd127;
    end else begin
      return s[6:0];
    end
  endfunction
`else
  // Extend is a no-op in this build; keep its inputs visibly consumed.
  logic unused_extend_s;
  assign unused_extend_s = ^{extend, 8'(EXTEND_SEC)};
`endif

  assign wrap_s = (presc_q == PW'(CLK_PER_SEC - 1));

  // Next-state logic: load first, then countdown/hold/extend while active.
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    presc_d  = presc_q;
    dec_s    = 1'b0;
    base_s   = time_q;
    expire_s = 1'b0;

    if (load) begin
      presc_d = '0;
      if (loadTime != 7'd0) begin
        state_d = RUN;
        time_d  = loadTime;
      end else begin
        state_d = DONE;
        time_d  = 7'd0;
      end
    end else begin
      case (state_q)
        RUN, HOLD: begin
          // Counting depends only on hold, so a phase held for N cycles
          // expires exactly N cycles late.
          if (!hold) begin
            if (wrap_s) begin
              presc_d = '0;
              dec_s   = 1'b1;
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end else begin
            presc_d = presc_q;
          end

          if (dec_s) begin
            base_s = time_q - 7'd1;
          end else begin
            base_s = time_q;
          end

`ifdef PHASE_TIMER_EXTEND_EN
          // An extend landing on the final decrement revives the phase.
          if (extend) begin
            time_d   = sat_add_f(base_s);
            expire_s = 1'b0;
          end else begin
            time_d   = base_s;
            expire_s = dec_s && (time_q == 7'd1);
          end
`else
          time_d   = base_s;
          expire_s = dec_s && (time_q == 7'd1);
`endif

          if (expire_s) begin
            state_d = DONE;
          end else if (hold) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          time_d  = 7'd0;
          presc_d = '0;
        end
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      time_q  <= 7'd0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign timeLeft  = time_q;
  assign busy      = busy_q;
  assign phaseDone = done_q;

endmodule

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
//   Directed and randomized checks of phase_timer (CLK_PER_SEC=10,
//   EXTEND_SEC=5). The reference model tracks the phase as a count of
//   remaining clock cycles; timeLeft is that count rounded up to seconds.
// -----------------------------------------------------------------------------
module tb_phase_timer;

  localparam int C = 10;
  localparam int E = 5;
`ifdef PHASE_TIMER_EXTEND_EN
  localparam bit EXT_ON = 1'b1;
`else
  localparam bit EXT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic [6:0] loadTime;
  logic       load;
  logic       hold;
  logic       extend;
  logic [6:0] timeLeft;
  logic       busy;
  logic       phaseDone;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int m_rem    = 0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;

  phase_timer #(.CLK_PER_SEC(C), .EXTEND_SEC(E)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .loadTime (loadTime),
    .load     (load),
    .hold     (hold),
    .extend   (extend),
    .timeLeft (timeLeft),
    .busy     (busy),
    .phaseDone(phaseDone)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ceil_sec(input int r);
    return (r + C - 1) / C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_active = 1'b0; m_done = 1'b0;
  endtask

  // One clock of the phase rules, expressed in remaining cycles.
  task automatic model_cycle(input bit ld, input int lt, input bit hd, input bit ex);
    int t, tn;
    if (ld) begin
      m_rem    = lt * C;
      m_active = (lt != 0);
      m_done   = (lt == 0);
    end else if (m_active) begin
      if (!hd) m_rem--;
      if (EXT_ON && ex) begin
        t  = ceil_sec(m_rem);
        tn = (t + E > 127) ? 127 : t + E;
        m_rem += (tn - t) * C;
      end
      m_done   = (m_rem == 0);
      m_active = (m_rem != 0);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic step(input logic ld, input logic [6:0] lt, input logic hd, input logic ex);
    load = ld; loadTime = lt; hold = hd; extend = ex;
    @(posedge clk);
    cyc++;
    model_cycle(ld, int'(lt), hd, ex);
    #1;
    chk("timeLeft", 32'(timeLeft), 32'(ceil_sec(m_rem)));
    chk("busy", 32'(busy), 32'(m_active));
    chk("phaseDone", 32'(phaseDone), 32'(m_done));
  endtask

  // Load a phase, optionally hold it, and measure when phaseDone appears.
  task automatic run_phase(input logic [6:0] lt, input int hold_at, input int hold_len,
                           input int exp_delay);
    int start, first, pulses;
    step(1'b1, lt, 1'b0, 1'b0);
    start = cyc; first = -1; pulses = 0;
    if (phaseDone === 1'b1) begin pulses++; first = cyc; end
    for (int i = 1; i <= exp_delay + 5; i++) begin
      step(1'b0, 7'd0, (i > hold_at) && (i <= hold_at + hold_len), 1'b0);
      if (phaseDone === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    chk("done_delay", 32'(first - start), 32'(exp_delay));
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int start, reload, first, early, hb;
    logic       r_ld, r_hd, r_ex;
    logic [6:0] r_lt;

    resetN = 1'b0; load = 1'b0; hold = 1'b0; extend = 1'b0; loadTime = 7'd0;
    #12;
    chk("rst_timeLeft", 32'(timeLeft), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_phaseDone", 32'(phaseDone), 32'd0);
    resetN = 1'b1;

    // hold/extend are ignored while idle
    step(1'b0, 7'd0, 1'b1, 1'b1);
    step(1'b0, 7'd9, 1'b0, 1'b1);

    // 25-second phase, no hold
    run_phase(7'd25, 0, 0, 250);
    // zero-length phase: pulse right away, never busy
    run_phase(7'd0, 0, 0, 0);
    // 25-second phase held for 37 cycles mid-run
    run_phase(7'd25, 80, 37, 287);

    // reload with 3 seconds at cycle 100 of a 25-second phase
    step(1'b1, 7'd25, 1'b0, 1'b0);
    start = cyc; early = 0;
    for (int i = 1; i < 100; i++) begin
      step(1'b0, 7'd0, 1'b0, 1'b0);
      if (phaseDone === 1'b1) early++;
    end
    step(1'b1, 7'd3, 1'b1, 1'b1);
    reload = cyc;
    chk("reload_start", 32'(reload - start), 32'd100);
    chk("reload_timeLeft", 32'(timeLeft), 32'd3);
    first = -1;
    for (int i = 0; i < 35; i++) begin
      step(1'b0, 7'd0, 1'b0, 1'b0);
      if (phaseDone === 1'b1 && first < 0) first = cyc;
      if (phaseDone === 1'b1 && first != cyc) early++;
    end
    chk("reload_delay", 32'(first - reload), 32'd30);
    chk("reload_extra_pulses", 32'(early), 32'd0);

    // extend on the final decrement, then extend near the ceiling
    step(1'b1, 7'd1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 7'd0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b1);
    chk("ext_last_timeLeft", 32'(timeLeft), EXT_ON ? 32'd5 : 32'd0);
    chk("ext_last_phaseDone", 32'(phaseDone), EXT_ON ? 32'd0 : 32'd1);
    step(1'b1, 7'd125, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b1);
    chk("ext_125", 32'(timeLeft), EXT_ON ? 32'd127 : 32'd125);
    step(1'b0, 7'd0, 1'b1, 1'b1);
    chk("ext_sat", 32'(timeLeft), EXT_ON ? 32'd127 : 32'd125);
    step(1'b1, 7'd0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b0);

    // asynchronous reset 120 cycles into a 25-second phase
    step(1'b1, 7'd25, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) step(1'b0, 7'd0, 1'b0, 1'b0);
    #3;
    resetN = 1'b0;
    model_reset();
    #1;
    chk("async_timeLeft", 32'(timeLeft), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_phaseDone", 32'(phaseDone), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    chk("inreset_phaseDone", 32'(phaseDone), 32'd0);
    chk("inreset_timeLeft", 32'(timeLeft), 32'd0);
    resetN = 1'b1;
    step(1'b0, 7'd0, 1'b0, 1'b0);
    run_phase(7'd25, 0, 0, 250);

    // randomized traffic against the model
    hb = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hb == 0 && $urandom_range(0, 29) == 0) hb = int'($urandom_range(1, 40));
      r_hd = (hb > 0);
      if (hb > 0) hb--;
      r_ld = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) r_lt = 7'($urandom_range(120, 127));
      else r_lt = 7'($urandom_range(0, 12));
      r_ex = ($urandom_range(0, 19) == 0);
      step(r_ld, r_lt, r_hd, r_ex);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
